// File: rtl/board_updater.sv
// Move validation and board update for a 3x3-of-3x3 game: writes the micro cell,
// closes the sub-board on a win or draw, and detects end of game on the macro board.
module board_updater (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       start,
  input  logic       jogador,
  input  logic [8:0] macro,
  input  logic [8:0] micro,
  input  logic [3:0] rd_addr,
  output logic [1:0] rd_estado,
  output logic       busy,
  output logic       done,
  output logic       invalida,
  output logic       macro_fechado,
  output logic       fim_jogo,
  output logic [1:0] vencedor
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CHECK      = 3'd1;
  localparam logic [2:0] S_WRITE      = 3'd2;
  localparam logic [2:0] S_SCAN_MICRO = 3'd3;
  localparam logic [2:0] S_UPD_MACRO  = 3'd4;
  localparam logic [2:0] S_SCAN_MACRO = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam logic [1:0] CODE_DRAW = 2'b11;

  logic [2:0]        state;
  logic [80:0][1:0]  micro_b;
  logic [8:0][1:0]   macro_b;
  logic [8:0]        mac_oh, mic_oh;
  logic [1:0]        code;
  logic [2:0]        line;
  logic              win;

  logic [3:0]        mac_idx, mic_idx;
  logic [6:0]        base, micro_addr;
  logic [11:0]       cells;
  logic [3:0]        la, lb, lc;
  logic              micro_hit, macro_hit, sub_full, macro_full, move_bad;

  function automatic logic onehot9(input logic [8:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, v[i]};
    return n == 4'd1;
  endfunction

  function automatic logic [3:0] idx9(input logic [8:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 9; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Win lines in scan order, packed as three 4-bit cell indices.
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    logic [11:0] r;
    case (l)
      3'd0:    r = {4'd0, 4'd1, 4'd2};
      3'd1:    r = {4'd3, 4'd4, 4'd5};
      3'd2:    r = {4'd6, 4'd7, 4'd8};
      3'd3:    r = {4'd0, 4'd3, 4'd6};
      3'd4:    r = {4'd1, 4'd4, 4'd7};
      3'd5:    r = {4'd2, 4'd5, 4'd8};
      3'd6:    r = {4'd0, 4'd4, 4'd8};
      default: r = {4'd2, 4'd4, 4'd6};
    endcase
    return r;
  endfunction

  assign mac_idx    = idx9(mac_oh);
  assign mic_idx    = idx9(mic_oh);
  assign base       = 7'(mac_idx) * 7'd9;
  assign micro_addr = base + 7'(mic_idx);

  assign cells = line_cells(line);
  assign la    = cells[11:8];
  assign lb    = cells[7:4];
  assign lc    = cells[3:0];

  // A draw code never equals a player code, so 11 cells drop out of macro wins naturally.
  assign micro_hit = (micro_b[base + 7'(la)] == code) && (micro_b[base + 7'(lb)] == code) &&
                     (micro_b[base + 7'(lc)] == code);
  assign macro_hit = (macro_b[la] == code) && (macro_b[lb] == code) && (macro_b[lc] == code);

  always_comb begin
    sub_full = 1'b1;
    for (int k = 0; k < 9; k++)
      if (micro_b[base + 7'(k)] == 2'b00) sub_full = 1'b0;
  end

  always_comb begin
    macro_full = 1'b1;
    for (int k = 0; k < 9; k++)
      if (macro_b[k] == 2'b00) macro_full = 1'b0;
  end

  assign move_bad = !onehot9(mac_oh) || !onehot9(mic_oh) || fim_jogo ||
                    (macro_b[mac_idx] != 2'b00) || (micro_b[micro_addr] != 2'b00);

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      micro_b       <= '0;
      macro_b       <= '0;
      mac_oh        <= '0;
      mic_oh        <= '0;
      code          <= '0;
      line          <= '0;
      win           <= 1'b0;
      done          <= 1'b0;
      invalida      <= 1'b0;
      macro_fechado <= 1'b0;
      fim_jogo      <= 1'b0;
      vencedor      <= '0;
    end else if (clear) begin
      state         <= S_IDLE;
      micro_b       <= '0;
      macro_b       <= '0;
      mac_oh        <= '0;
      mic_oh        <= '0;
      code          <= '0;
      line          <= '0;
      win           <= 1'b0;
      done          <= 1'b0;
      invalida      <= 1'b0;
      macro_fechado <= 1'b0;
      fim_jogo      <= 1'b0;
      vencedor      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mac_oh        <= macro;
            mic_oh        <= micro;
            code          <= jogador ? 2'b10 : 2'b01;
            invalida      <= 1'b0;
            macro_fechado <= 1'b0;
            state         <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (move_bad) begin
            invalida <= 1'b1;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          micro_b[micro_addr] <= code;
          line                <= 3'd0;
          win                 <= 1'b0;
          state               <= S_SCAN_MICRO;
        end
        S_SCAN_MICRO: begin
          win  <= win | micro_hit;
          line <= line + 3'd1;
          if (line == 3'd7) state <= S_UPD_MACRO;
        end
        S_UPD_MACRO: begin
          if (win || sub_full) begin
            macro_b[mac_idx] <= win ? code : CODE_DRAW;
            macro_fechado    <= 1'b1;
            line             <= 3'd0;
            win              <= 1'b0;
            state            <= S_SCAN_MACRO;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_SCAN_MACRO: begin
          win  <= win | macro_hit;
          line <= line + 3'd1;
          if (line == 3'd7) begin
            if (win || macro_hit) begin
              fim_jogo <= 1'b1;
              vencedor <= code;
            end else if (macro_full) begin
              fim_jogo <= 1'b1;
              vencedor <= CODE_DRAW;
            end
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)               rd_estado <= 2'b00;
    else if (clear)          rd_estado <= 2'b00;
    else if (rd_addr < 4'd9) rd_estado <= macro_b[rd_addr];
    else                     rd_estado <= 2'b00;
  end

endmodule

// File: tb/tb_board_updater.sv
// Directed moves with a done-driven scoreboard for board_updater.
module tb_board_updater;

  logic       clock, reset, clear, start, jogador;
  logic [8:0] macro, micro;
  logic [3:0] rd_addr;
  logic [1:0] rd_estado;
  logic       busy, done, invalida, macro_fechado, fim_jogo;
  logic [1:0] vencedor;

  board_updater dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start), .jogador(jogador),
    .macro(macro), .micro(micro), .rd_addr(rd_addr), .rd_estado(rd_estado),
    .busy(busy), .done(done), .invalida(invalida), .macro_fechado(macro_fechado),
    .fim_jogo(fim_jogo), .vencedor(vencedor)
  );

  typedef struct {
    int         cyc;
    logic       inv;
    logic       fech;
    logic       fim;
    logic [1:0] venc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_invalida"}, invalida, e.inv);
        chk({e.name, "_fechado"}, macro_fechado, e.fech);
        chk({e.name, "_fim"}, fim_jogo, e.fim);
        chk({e.name, "_vencedor"}, vencedor, e.venc);
      end
    end
  end

  function automatic logic [8:0] oh(input int i);
    logic [8:0] one;
    one = 9'd1;
    return one << i;
  endfunction

  task automatic wait_done(input int n0, input string nm);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      #1;
      if (done_cnt != n0) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
  endtask

  task automatic do_move(input logic [8:0] m, input logic [8:0] u, input logic p,
                         input logic inv, input logic fech, input logic fim,
                         input logic [1:0] venc, input int lat, input string nm);
    int t, n0;
    @(negedge clock);
    macro = m; micro = u; jogador = p; start = 1'b1;
    t = cyc;
    sb.push_back('{t + lat, inv, fech, fim, venc, nm});
    n0 = done_cnt;
    @(negedge clock);
    start = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    wait_done(n0, nm);
  endtask

  task automatic read_chk(input int a, input int exp, input string nm);
    @(negedge clock);
    rd_addr = 4'(a);
    @(negedge clock);
    chk(nm, rd_estado, exp);
  endtask

  // Sub-board draw: X O X / X O O / O X X  (X = player 0)
  logic draw_p [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int t;
    reset = 1'b1; clear = 1'b0; start = 1'b0; jogador = 1'b0;
    macro = '0; micro = '0; rd_addr = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_invalida", invalida, 0);
    chk("rst_fechado", macro_fechado, 0);
    chk("rst_fim", fim_jogo, 0);
    chk("rst_vencedor", vencedor, 0);
    chk("rst_rd", rd_estado, 0);

    do_move(oh(0), oh(1), 1'b0, 0, 0, 0, 2'b00, 12, "first");
    do_move(oh(0), oh(1), 1'b0, 1, 0, 0, 2'b00, 2, "repeat");
    do_move(oh(0), 9'b000000011, 1'b0, 1, 0, 0, 2'b00, 2, "not_onehot");
    read_chk(0, 0, "rd_m0_empty");

    do_move(oh(3), oh(0), 1'b0, 0, 0, 0, 2'b00, 12, "m3c0");
    do_move(oh(7), oh(0), 1'b1, 0, 0, 0, 2'b00, 12, "m7c0");
    do_move(oh(3), oh(4), 1'b0, 0, 0, 0, 2'b00, 12, "m3c4");
    do_move(oh(7), oh(1), 1'b1, 0, 0, 0, 2'b00, 12, "m7c1");
    do_move(oh(3), oh(8), 1'b0, 0, 1, 0, 2'b00, 20, "m3c8_win");
    read_chk(3, 1, "rd_m3_p0");
    read_chk(9, 0, "rd_addr9");

    for (int c = 0; c < 9; c++)
      do_move(oh(5), oh(c), draw_p[c], 0, (c == 8), 0, 2'b00, (c == 8) ? 20 : 12,
              $sformatf("draw_c%0d", c));
    read_chk(5, 3, "rd_m5_draw");

    for (int mi = 2; mi <= 6; mi += 2)
      for (int c = 0; c < 3; c++)
        do_move(oh(mi), oh(c), 1'b1, 0, (c == 2), (mi == 6 && c == 2),
                (mi == 6 && c == 2) ? 2'b10 : 2'b00, (c == 2) ? 20 : 12,
                $sformatf("p1_m%0d_c%0d", mi, c));
    read_chk(4, 2, "rd_m4_p1");
    do_move(oh(0), oh(5), 1'b0, 1, 0, 1, 2'b10, 2, "after_over");

    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    #1;
    chk("clr_fim", fim_jogo, 0);
    chk("clr_vencedor", vencedor, 0);
    for (int a = 0; a < 9; a++) read_chk(a, 0, $sformatf("clr_rd_m%0d", a));

    // clear mid-move: no done, and the cell is free again afterwards
    @(negedge clock);
    macro = oh(0); micro = oh(0); jogador = 1'b0; start = 1'b1; t = cyc;
    @(negedge clock); start = 1'b0;
    while (cyc < t + 5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    repeat (25) @(negedge clock);
    chk("clr_abort_busy", busy, 0);
    do_move(oh(0), oh(0), 1'b0, 0, 0, 0, 2'b00, 12, "after_clear_abort");

    // async reset mid-scan wipes the freshly written cell
    @(negedge clock);
    macro = oh(1); micro = oh(4); jogador = 1'b0; start = 1'b1; t = cyc;
    @(negedge clock); start = 1'b0;
    while (cyc < t + 6) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_invalida", invalida, 0);
    chk("rstmid_fim", fim_jogo, 0);
    chk("rstmid_rd", rd_estado, 0);
    @(negedge clock); reset = 1'b0;
    do_move(oh(1), oh(4), 1'b0, 0, 0, 0, 2'b00, 12, "after_reset_m1c4");
    do_move(oh(0), oh(0), 1'b0, 0, 0, 0, 2'b00, 12, "after_reset_m0c0");

    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
